ahb_lite_master_bridge: RTL
===========================

Name: ahb_lite_master_bridge

Overview:
- Downstream stage of the SPI flash controller's DMA-side master port: consumes the simple valid/ready request stream (addr, wr_data, rd0_wr1) that the SPI FSM produces and drives a single AHB-Lite master bus.
- Buffers requests in a small command FIFO and issues single-word NONSEQ transfers with address/data phase pipelining.
- Handles HREADY wait states and the two-cycle HRESP error, returns read data, and latches a sticky error with its address.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
ahbclk  in  1  AHB clock, all logic on rising edge
ahbrst  in  1  synchronous reset, active-high
i_valid  in  1  request valid from SPI FSM
i_addr  in  AW  request byte address
i_wr_data  in  DW  write data
i_rd0_wr1  in  1  0=read, 1=write
o_ready  out  1  request accepted when i_valid&o_ready
o_rd_data  out  DW  read return data
o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
o_err  out  1  sticky bus-error flag
o_err_addr  out  AW  address of first errored transfer
i_err_clr  in  1  clears o_err (1-cycle pulse)
o_idle  out  1  FIFO empty and no data phase outstanding
HADDR  out  AW  AHB address
HTRANS  out  2  IDLE=00 / NONSEQ=10 only
HWRITE  out  1  AHB write
HSIZE  out  3  constant 3'b010
HBURST  out  3  constant 3'b000
HPROT  out  4  constant 4'b0011
HWDATA  out  DW  write data, data phase
HRDATA  in  DW  read data
HREADY  in  1  transfer ready
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (ahbrst=1 at edge): FIFO emptied (pending requests discarded), data-phase slot invalid, cancel flag 0. Outputs next cycle: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, o_rd_valid=0, o_rd_data=0, o_err=0, o_err_addr=0, o_ready=1, o_idle=1. Reset mid-transfer simply abandons the transfer.
- FIFO: push on i_valid&o_ready; o_ready=!full (registered count, so no push in the same cycle as a pop from full). Push and pop in the same cycle are allowed when not full. Wrap-around uses DEPTH-sized pointers with an extra wrap bit.
- Address phase: combinational from FIFO head. HTRANS=NONSEQ when FIFO non-empty and cancel=0, else IDLE. HADDR={head_addr[AW-1:2],2'b00} (forced word-aligned), HWRITE=head_rd0_wr1. Outputs hold stable while HREADY=0.
- Accept: address phase is accepted when HTRANS=NONSEQ&HREADY. That cycle: pop FIFO, load data-phase slot {valid=1, write, addr, wdata}. HWDATA is registered from the slot and is valid through the whole data phase.
- Pipelining: the next head may present NONSEQ during the current data phase; back-to-back transfers sustain 1 per cycle at zero wait states.
- Data phase completes on HREADY=1 with slot valid. Slot clears unless reloaded by a simultaneous accept.
  - Read OKAY: o_rd_data<=HRDATA, o_rd_valid=1 in the next cycle (latency 1 from HREADY).
  - Write OKAY: no return signalling.
- Error, cycle 1 (HRESP=1, HREADY=0, slot valid):
  - Set cancel=1.
  - If o_err=0: o_err<=1, o_err_addr<=slot addr. Later errors do not overwrite o_err_addr.
  - The address-phase transfer shown that cycle is not accepted (HREADY=0) and stays in the FIFO.
- Error, cycle 2 (cancel=1):
  - HTRANS forced IDLE.
  - When HREADY=1 (HRESP=1): slot clears, cancel<=0, no o_rd_valid for the errored read.
  - Issue resumes with the retained head the following cycle. Nothing is dropped except the errored transfer.
- i_err_clr: o_err<=0. If a new error cycle 1 coincides, set wins.
- o_idle = FIFO empty & slot invalid & cancel=0.

Test Plan:
- Single write, HREADY=1: push addr 0x2000_0004, data 0xDEADBEEF, wr -> cycle n: HTRANS=10, HADDR=0x20000004, HWRITE=1; cycle n+1: HWDATA=0xDEADBEEF, HTRANS=00; o_idle=1 at n+2.
- Burst of 4 reads 0x100..0x10C, zero wait states, slave returns 0xA0..0xA3 -> NONSEQ on 4 consecutive cycles; o_rd_valid pulses 4 consecutive cycles with data 0xA0,0xA1,0xA2,0xA3 in order.
- Wait states: slave holds HREADY=0 for 3 cycles in a write data phase while a read is pending -> HADDR/HTRANS/HWDATA stable all 3 cycles; read accepted only on the HREADY=1 cycle.
- FIFO full: push 5 requests with HREADY=0 and DEPTH=4 -> o_ready=0 after the 4th accept; release HREADY -> o_ready returns 1 after the first pop; all 5 issue in order.
- Error: write to 0x300 gets ERROR (cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1) with read 0x304 queued -> o_err=1, o_err_addr=0x300; HTRANS=00 in cycle 2; 0x304 reissued next cycle and returns data; second error leaves o_err_addr=0x300; i_err_clr clears o_err.
- Reset mid-transfer: assert ahbrst during a HREADY=0 data phase with 2 queued -> next cycle HTRANS=00, o_idle=1, o_ready=1, no o_rd_valid.

Source files
------------

// File: rtl/ahb_lite_master_bridge_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_master_bridge_if
//   AHB-Lite single-master bus bundle.
//
//   Signals:
//     HADDR   AW   address phase byte address
//     HTRANS  2    IDLE=00 / NONSEQ=10
//     HWRITE  1    1=write
//     HSIZE   3    transfer size
//     HBURST  3    burst type
//     HPROT   4    protection attributes
//     HWDATA  DW   write data (data phase)
//     HRDATA  DW   read data (data phase)
//     HREADY  1    transfer ready / data phase complete
//     HRESP   1    0=OKAY, 1=ERROR
//
//   Modports:
//     master  drives address/control/write data, samples HRDATA/HREADY/HRESP
//     slave   the opposite view
// ----------------------------------------------------------------------------
interface ahb_lite_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// ----------------------------------------------------------------------------
// ahb_lite_master_bridge
//   Turns a valid/ready request stream (addr, wr_data, rd0_wr1) into single
//   word NONSEQ transfers on an AHB-Lite master bus. Requests are queued in a
//   DEPTH-entry command FIFO; the head of the FIFO drives the address phase
//   combinationally while the previous transfer sits in a one-entry data
//   phase slot, so back-to-back transfers run at one per cycle.
//
//   Ports:
//     ahbclk, ahbrst     clock, synchronous active-high reset
//     i_valid/o_ready    request handshake
//     i_addr, i_wr_data, i_rd0_wr1   request payload
//     o_rd_data, o_rd_valid          read return (one-cycle pulse)
//     o_err, o_err_addr, i_err_clr   sticky bus error and its address
//     o_idle             nothing queued, nothing in flight
//     ahb                AHB-Lite master modport
//
//   Request handshake: a request is transferred on every rising edge where
//   i_valid and o_ready are both high. o_ready depends only on registered
//   state (FIFO not full), never on i_valid. The requester holds its payload
//   stable while i_valid is high and o_ready is low.
// ----------------------------------------------------------------------------
module ahb_lite_master_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                          ahbclk,
    input  logic                          ahbrst,
    input  logic                          i_valid,
    input  logic [AW-1:0]                 i_addr,
    input  logic [DW-1:0]                 i_wr_data,
    input  logic                          i_rd0_wr1,
    output logic                          o_ready,
    output logic [DW-1:0]                 o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_err,
    output logic [AW-1:0]                 o_err_addr,
    input  logic                          i_err_clr,
    output logic                          o_idle,
    ahb_lite_master_bridge_if.master      ahb
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Command FIFO storage (no reset needed; validity comes from pointers)
    logic [AW-1:0] fifo_addr  [DEPTH];
    logic [DW-1:0] fifo_wdata [DEPTH];
    logic          fifo_wr    [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;

    logic [AW-1:0] head_addr;
    logic [AW-1:0] head_addr_aligned;
    logic [DW-1:0] head_wdata;
    logic          head_wr;

    // Data phase slot
    logic          slot_valid;
    logic          slot_write;
    logic [AW-1:0] slot_addr;
    logic [DW-1:0] hwdata_q;

    // Set during the second cycle of an ERROR response: suppresses issue
    logic          cancel;

    logic          push;
    logic          nonseq;
    logic          accept;
    logic          complete;
    logic          err_cycle1;
    logic          rd_done;

    // ------------------------------------------------------------------
    // FIFO status and head
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign head_addr         = fifo_addr[rd_ptr[PW-1:0]];
    assign head_wdata        = fifo_wdata[rd_ptr[PW-1:0]];
    assign head_wr           = fifo_wr[rd_ptr[PW-1:0]];
    assign head_addr_aligned = head_addr & {{(AW-2){1'b1}}, 2'b00};

    assign o_ready = !fifo_full;
    assign push    = i_valid && o_ready;

    // ------------------------------------------------------------------
    // Address phase: driven straight from the FIFO head. While HREADY is
    // low the head does not move, so address/control stay stable.
    // HADDR/HWRITE read zero when nothing is queued.
    // ------------------------------------------------------------------
    assign nonseq   = !fifo_empty && !cancel;
    assign accept   = nonseq && ahb.HREADY;

    assign ahb.HTRANS = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HADDR  = fifo_empty ? '0 : head_addr_aligned;
    assign ahb.HWRITE = !fifo_empty && head_wr;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = 4'b0011;
    assign ahb.HWDATA = hwdata_q;

    // ------------------------------------------------------------------
    // Data phase
    // ------------------------------------------------------------------
    assign complete   = slot_valid && ahb.HREADY;
    assign err_cycle1 = slot_valid && ahb.HRESP && !ahb.HREADY;
    // The cancel cycle always carries HRESP=1, but gate on cancel as well so
    // an errored read can never report data.
    assign rd_done    = complete && !slot_write && !ahb.HRESP && !cancel;

    assign o_idle = fifo_empty && !slot_valid && !cancel;

    // FIFO storage write
    always_ff @(posedge ahbclk) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]]  <= i_addr;
            fifo_wdata[wr_ptr[PW-1:0]] <= i_wr_data;
            fifo_wr[wr_ptr[PW-1:0]]    <= i_rd0_wr1;
        end
    end

    // Control state
    always_ff @(posedge ahbclk) begin
        if (ahbrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slot_valid <= 1'b0;
            slot_write <= 1'b0;
            slot_addr  <= '0;
            hwdata_q   <= '0;
            cancel     <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            o_err      <= 1'b0;
            o_err_addr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // A new accept reloads the slot even if the old phase completes
            // in the same cycle; otherwise a completing phase empties it.
            if (accept) begin
                rd_ptr     <= rd_ptr + 1'b1;
                slot_valid <= 1'b1;
                slot_write <= head_wr;
                slot_addr  <= head_addr_aligned;
                hwdata_q   <= head_wdata;
            end else if (complete) begin
                slot_valid <= 1'b0;
            end

            if (err_cycle1) begin
                cancel <= 1'b1;
            end else if (cancel && ahb.HREADY) begin
                cancel <= 1'b0;
            end

            o_rd_valid <= rd_done;
            if (rd_done) begin
                o_rd_data <= ahb.HRDATA;
            end

            // Only the first error since the last clear records its address;
            // a fresh error wins over a simultaneous clear.
            if (err_cycle1) begin
                o_err <= 1'b1;
                if (!o_err) begin
                    o_err_addr <= slot_addr;
                end
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule
